// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU: opcodes, sequencer states and the
// bit layout of the decoded control vector.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    // Bit positions inside the decoder's control vector.
    localparam int CTL_A    = 0;
    localparam int CTL_B    = 1;
    localparam int CTL_ALU  = 2;
    localparam int CTL_SUB  = 3;
    localparam int CTL_OUT  = 4;
    localparam int CTL_JUMP = 5;
    localparam int CTL_W    = 6;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: maps an opcode and the datapath flags to the
// control vector that the sequencer applies during EXECUTE.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             carry_flag,
    output logic [CTL_W-1:0] ctl
);

    always_comb begin
        // NOTE: the default assignment first means every path drives ctl, so no latch is inferred.
        ctl = '0;
        case (opcode)
            OP_LDA: ctl[CTL_A]    = 1'b1;
            OP_LDB: ctl[CTL_B]    = 1'b1;
            OP_ADD: ctl[CTL_ALU]  = 1'b1;
            OP_SUB: begin
                ctl[CTL_ALU] = 1'b1;
                ctl[CTL_SUB] = 1'b1;
            end
            OP_OUT: ctl[CTL_OUT]  = 1'b1;
            OP_JMP: ctl[CTL_JUMP] = 1'b1;
            OP_JZ:  ctl[CTL_JUMP] = zero_flag;
            OP_JC:  ctl[CTL_JUMP] = carry_flag;
            // NOP, HLT and the undefined opcodes issue no strobe.
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: FETCH/DECODE/EXECUTE loop with a terminal HALTED
// state; drives PC control and one datapath strobe per instruction.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr_in,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       ir_load_en,
    output logic       jump_en,
    output logic [3:0] jump_addr,
    output logic       halt,
    output logic       a_load_en,
    output logic       b_load_en,
    output logic       alu_load_en,
    output logic       alu_sub,
    output logic       out_load_en,
    output logic [3:0] operand,
    output logic [7:0] ir_out
);

    state_t           state;
    state_t           state_next;
    logic [7:0]       ir;
    logic [CTL_W-1:0] ctl;

    instr_decoder u_decoder (
        .opcode     (ir[7:4]),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .ctl        (ctl)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state <= S_FETCH;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            if (state == S_FETCH) ir <= instr_in;
        end
    end

    always_comb begin
        state_next  = state;
        ir_load_en  = 1'b0;
        jump_en     = 1'b0;
        halt        = 1'b0;
        a_load_en   = 1'b0;
        b_load_en   = 1'b0;
        alu_load_en = 1'b0;
        alu_sub     = 1'b0;
        out_load_en = 1'b0;
        // While reset is held every control output stays quiet, even in FETCH.
        if (reset) begin
            case (state)
                S_FETCH: begin
                    ir_load_en = 1'b1;
                    state_next = S_DECODE;
                end
                S_DECODE: state_next = S_EXECUTE;
                S_EXECUTE: begin
                    a_load_en   = ctl[CTL_A];
                    b_load_en   = ctl[CTL_B];
                    alu_load_en = ctl[CTL_ALU];
                    alu_sub     = ctl[CTL_SUB];
                    out_load_en = ctl[CTL_OUT];
                    jump_en     = ctl[CTL_JUMP];
                    state_next  = (ir[7:4] == OP_HLT) ? S_HALTED : S_FETCH;
                end
                S_HALTED: halt = 1'b1;
                default:  state_next = S_FETCH;
            endcase
        end
    end

    assign jump_addr = ir[3:0];
    assign operand   = ir[3:0];
    assign ir_out    = ir;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed program steps plus random instructions,
// checked every cycle against a cycle-count model of the sequencer.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr_in;
    logic       zero_flag;
    logic       carry_flag;
    logic       ir_load_en;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       halt;
    logic       a_load_en;
    logic       b_load_en;
    logic       alu_load_en;
    logic       alu_sub;
    logic       out_load_en;
    logic [3:0] operand;
    logic [7:0] ir_out;

    always #5 clk = ~clk;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .ir_load_en  (ir_load_en),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .a_load_en   (a_load_en),
        .b_load_en   (b_load_en),
        .alu_load_en (alu_load_en),
        .alu_sub     (alu_sub),
        .out_load_en (out_load_en),
        .operand     (operand),
        .ir_out      (ir_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: cycles since reset release (instruction phase = k % 3), halted
    // flag and the instruction most recently fetched.
    int         k;
    bit         halted;
    logic [7:0] m_ir;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [7:0] ins, input logic z, input logic c);
        logic e_ir, e_j, e_h, e_a, e_b, e_alu, e_sub, e_out;
        @(negedge clk);
        reset      = r;
        instr_in   = ins;
        zero_flag  = z;
        carry_flag = c;
        #1;
        {e_ir, e_j, e_h, e_a, e_b, e_alu, e_sub, e_out} = '0;
        if (r && halted) begin
            e_h = 1'b1;
        end else if (r) begin
            if (k % 3 == 0) e_ir = 1'b1;
            if (k % 3 == 2) begin
                case (m_ir[7:4])
                    4'h1: e_a = 1'b1;
                    4'h2: e_b = 1'b1;
                    4'h3: e_alu = 1'b1;
                    4'h4: begin e_alu = 1'b1; e_sub = 1'b1; end
                    4'h5: e_out = 1'b1;
                    4'h6: e_j = 1'b1;
                    4'h7: e_j = z;
                    4'h8: e_j = c;
                    default: ;
                endcase
            end
        end
        check("ir_load_en",  {7'd0, ir_load_en},  {7'd0, e_ir});
        check("jump_en",     {7'd0, jump_en},     {7'd0, e_j});
        check("halt",        {7'd0, halt},        {7'd0, e_h});
        check("a_load_en",   {7'd0, a_load_en},   {7'd0, e_a});
        check("b_load_en",   {7'd0, b_load_en},   {7'd0, e_b});
        check("alu_load_en", {7'd0, alu_load_en}, {7'd0, e_alu});
        check("alu_sub",     {7'd0, alu_sub},     {7'd0, e_sub});
        check("out_load_en", {7'd0, out_load_en}, {7'd0, e_out});
        check("ir_out",      ir_out,              m_ir);
        check("operand",     {4'd0, operand},     {4'd0, m_ir[3:0]});
        check("jump_addr",   {4'd0, jump_addr},   {4'd0, m_ir[3:0]});
        // Advance the model past the coming rising edge.
        if (!r) begin
            k      = 0;
            halted = 1'b0;
            m_ir   = 8'h00;
        end else if (!halted) begin
            if (k % 3 == 0) m_ir = ins;
            if (k % 3 == 2 && m_ir[7:4] == 4'hF) halted = 1'b1;
            k++;
        end
        cyc++;
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic z, input logic c);
        for (int i = 0; i < 3; i++) cycle(1'b1, ins, z, c);
    endtask

    initial begin
        logic [7:0] rnd_ins;
        reset      = 1'b0;
        instr_in   = 8'h00;
        zero_flag  = 1'b0;
        carry_flag = 1'b0;
        @(posedge clk);
        k      = 0;
        halted = 1'b0;
        m_ir   = 8'h00;

        // Reset held two cycles, then idle NOPs.
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        run_instr(8'h00, 1'b0, 1'b0);
        run_instr(8'h00, 1'b0, 1'b0);

        // Loads, ALU and output.
        run_instr(8'h13, 1'b0, 1'b0);
        run_instr(8'h25, 1'b0, 1'b0);
        run_instr(8'h30, 1'b0, 1'b0);
        run_instr(8'h41, 1'b0, 1'b0);
        run_instr(8'h50, 1'b0, 1'b0);

        // Jumps: unconditional, then each conditional not-taken / taken.
        run_instr(8'h6A, 1'b0, 1'b0);
        run_instr(8'h74, 1'b0, 1'b1);
        run_instr(8'h74, 1'b1, 1'b0);
        run_instr(8'h84, 1'b1, 1'b0);
        run_instr(8'h84, 1'b0, 1'b1);

        // Undefined opcode behaves as NOP.
        run_instr(8'hB7, 1'b1, 1'b1);
        run_instr(8'h13, 1'b0, 1'b0);

        // Reset during DECODE of LDA drops its strobe.
        cycle(1'b1, 8'h13, 1'b0, 1'b0);
        cycle(1'b0, 8'h13, 1'b0, 1'b0);
        run_instr(8'h00, 1'b0, 1'b0);
        run_instr(8'h25, 1'b0, 1'b0);

        // Random program without HLT; flags change every cycle.
        for (int i = 0; i < 60; i++) begin
            rnd_ins = {4'($urandom_range(0, 14)), 4'($urandom)};
            for (int j = 0; j < 3; j++)
                cycle(1'b1, rnd_ins, 1'($urandom), 1'($urandom));
        end

        // Halt, hold while instr_in changes, then reset out of it.
        run_instr(8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        run_instr(8'h13, 1'b0, 1'b0);
        run_instr(8'h6C, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
